// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage feeding the ALU: register file, operand select, 1-entry output register.
// Optional same-edge write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module alu_operand_stage #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] IN_SRC1,
    input  logic [AW-1:0] IN_SRC2,
    input  logic [DW-1:0] IN_IMM,
    input  logic          IN_IMM_SEL,
    input  logic [2:0]    IN_SELECT,
    input  logic [AW-1:0] IN_DEST,
    input  logic          IN_WB,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA1,
    output logic [DW-1:0] OUT_DATA2,
    output logic [2:0]    OUT_SELECT,
    output logic [AW-1:0] OUT_DEST,
    output logic          OUT_WB,
    input  logic          FLUSH,
    input  logic          WRITE_EN,
    input  logic [AW-1:0] WRITE_REG,
    input  logic [DW-1:0] WRITE_DATA
);

    localparam int unsigned SEL_W = 3;

    typedef struct packed {
        logic [DW-1:0]    data1;
        logic [DW-1:0]    data2;
        logic [SEL_W-1:0] select;
        logic [AW-1:0]    dest;
        logic             wb;
    } op_t;

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    op_t           op_q;
    op_t           op_d;
    logic          valid_q;
    logic          valid_d;

    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          accept;

    // Single-entry stage with no skid buffer: ready only when the slot is free or draining.
    assign IN_READY = !valid_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY && !FLUSH;

    // Source reads, optionally forwarding a write landing on the same edge.
    always_comb begin
        rd1 = regs_q[IN_SRC1];
        rd2 = regs_q[IN_SRC2];
`ifdef REGFILE_BYPASS_EN
        if (WRITE_EN && (WRITE_REG == IN_SRC1)) begin
            rd1 = WRITE_DATA;
        end
        if (WRITE_EN && (WRITE_REG == IN_SRC2)) begin
            rd2 = WRITE_DATA;
        end
`endif
    end

    always_comb begin
        regs_d = regs_q;
        if (WRITE_EN) begin
            regs_d[WRITE_REG] = WRITE_DATA;
        end
    end

    // Output register next state: flush beats accept, accept beats drain, otherwise hold.
    always_comb begin
        op_d    = op_q;
        valid_d = valid_q;
        if (FLUSH) begin
            valid_d = 1'b0;
        end else if (accept) begin
            op_d.data1  = rd1;
            op_d.data2  = IN_IMM_SEL ? IN_IMM : rd2;
            op_d.select = IN_SELECT;
            op_d.dest   = IN_DEST;
            op_d.wb     = IN_WB;
            valid_d     = 1'b1;
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign OUT_VALID  = valid_q;
    assign OUT_DATA1  = op_q.data1;
    assign OUT_DATA2  = op_q.data2;
    assign OUT_SELECT = op_q.select;
    assign OUT_DEST   = op_q.dest;
    assign OUT_WB     = op_q.wb;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; expected values are hand-computed.
module tb_alu_operand_stage;

    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          IN_VALID;
    logic          IN_READY;
    logic [AW-1:0] IN_SRC1;
    logic [AW-1:0] IN_SRC2;
    logic [DW-1:0] IN_IMM;
    logic          IN_IMM_SEL;
    logic [2:0]    IN_SELECT;
    logic [AW-1:0] IN_DEST;
    logic          IN_WB;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA1;
    logic [DW-1:0] OUT_DATA2;
    logic [2:0]    OUT_SELECT;
    logic [AW-1:0] OUT_DEST;
    logic          OUT_WB;
    logic          FLUSH;
    logic          WRITE_EN;
    logic [AW-1:0] WRITE_REG;
    logic [DW-1:0] WRITE_DATA;

    int errors = 0;
    int checks = 0;

    alu_operand_stage #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_SRC1(IN_SRC1), .IN_SRC2(IN_SRC2), .IN_IMM(IN_IMM), .IN_IMM_SEL(IN_IMM_SEL),
        .IN_SELECT(IN_SELECT), .IN_DEST(IN_DEST), .IN_WB(IN_WB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA1(OUT_DATA1), .OUT_DATA2(OUT_DATA2), .OUT_SELECT(OUT_SELECT),
        .OUT_DEST(OUT_DEST), .OUT_WB(OUT_WB),
        .FLUSH(FLUSH), .WRITE_EN(WRITE_EN), .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic isel,
                          input logic [DW-1:0] imm, input logic [2:0] sel,
                          input logic [AW-1:0] dst, input logic wb);
        IN_VALID   = 1'b1;
        IN_SRC1    = s1;
        IN_SRC2    = s2;
        IN_IMM_SEL = isel;
        IN_IMM     = imm;
        IN_SELECT  = sel;
        IN_DEST    = dst;
        IN_WB      = wb;
    endtask

    task automatic write_reg(input logic [AW-1:0] r, input logic [DW-1:0] d);
        WRITE_EN   = 1'b1;
        WRITE_REG  = r;
        WRITE_DATA = d;
    endtask

    logic [DW-1:0] exp_same_edge;

    initial begin
        RESET = 1'b1;
        IN_VALID = 1'b0; IN_SRC1 = '0; IN_SRC2 = '0; IN_IMM = '0; IN_IMM_SEL = 1'b0;
        IN_SELECT = '0; IN_DEST = '0; IN_WB = 1'b0; OUT_READY = 1'b1; FLUSH = 1'b0;
        WRITE_EN = 1'b0; WRITE_REG = '0; WRITE_DATA = '0;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        check("reset_valid", 64'(OUT_VALID), 64'd0);
        check("reset_in_ready", 64'(IN_READY), 64'd1);

        // Load operands: reg3=5, reg4=3.
        write_reg(3'd3, 32'h0000_0005);
        tick();
        write_reg(3'd4, 32'h0000_0003);
        tick();
        WRITE_EN = 1'b0;

        // Register/register op.
        set_op(3'd3, 3'd4, 1'b0, 32'h0, 3'b001, 3'd5, 1'b1);
        tick();
        check("rr_valid", 64'(OUT_VALID), 64'd1);
        check("rr_data1", 64'(OUT_DATA1), 64'h5);
        check("rr_data2", 64'(OUT_DATA2), 64'h3);
        check("rr_select", 64'(OUT_SELECT), 64'd1);
        check("rr_dest", 64'(OUT_DEST), 64'd5);
        check("rr_wb", 64'(OUT_WB), 64'd1);

        // Immediate op issued back-to-back.
        set_op(3'd3, 3'd4, 1'b1, 32'hFFFF_FFF0, 3'b010, 3'd1, 1'b0);
        tick();
        check("imm_valid", 64'(OUT_VALID), 64'd1);
        check("imm_data1", 64'(OUT_DATA1), 64'h5);
        check("imm_data2", 64'(OUT_DATA2), 64'hFFFF_FFF0);
        check("imm_select", 64'(OUT_SELECT), 64'd2);
        check("imm_wb", 64'(OUT_WB), 64'd0);

        // Back-pressure for three cycles with a new op waiting.
        OUT_READY = 1'b0;
        set_op(3'd4, 3'd3, 1'b0, 32'h0, 3'b011, 3'd2, 1'b1);
        #1;
        check("hold_in_ready", 64'(IN_READY), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 64'(OUT_VALID), 64'd1);
            check("hold_in_ready", 64'(IN_READY), 64'd0);
            check("hold_data2", 64'(OUT_DATA2), 64'hFFFF_FFF0);
            check("hold_select", 64'(OUT_SELECT), 64'd2);
        end
        OUT_READY = 1'b1;
        #1;
        check("release_in_ready", 64'(IN_READY), 64'd1);
        tick();
        check("release_valid", 64'(OUT_VALID), 64'd1);
        check("release_data1", 64'(OUT_DATA1), 64'h3);
        check("release_data2", 64'(OUT_DATA2), 64'h5);
        check("release_select", 64'(OUT_SELECT), 64'd3);
        check("release_dest", 64'(OUT_DEST), 64'd2);
        IN_VALID = 1'b0;
        tick();
        check("drain_valid", 64'(OUT_VALID), 64'd0);

        // Same-edge write and read of reg2; SELECT=7 passes through unchanged.
`ifdef REGFILE_BYPASS_EN
        exp_same_edge = 32'hA5A5_A5A5;
`else
        exp_same_edge = 32'h0;
`endif
        set_op(3'd2, 3'd0, 1'b0, 32'h0, 3'b111, 3'd7, 1'b1);
        write_reg(3'd2, 32'hA5A5_A5A5);
        tick();
        WRITE_EN = 1'b0;
        check("same_edge_data1", 64'(OUT_DATA1), 64'(exp_same_edge));
        check("same_edge_select", 64'(OUT_SELECT), 64'd7);
        tick();
        check("after_write_data1", 64'(OUT_DATA1), 64'hA5A5_A5A5);
        check("after_write_dest", 64'(OUT_DEST), 64'd7);

        // Flush while holding with an op waiting and a concurrent write.
        OUT_READY = 1'b0;
        set_op(3'd3, 3'd3, 1'b0, 32'h0, 3'b101, 3'd4, 1'b0);
        FLUSH = 1'b1;
        write_reg(3'd6, 32'h1234_5678);
        tick();
        check("flush_valid", 64'(OUT_VALID), 64'd0);
        FLUSH = 1'b0;
        WRITE_EN = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        tick();
        check("flush_no_ghost", 64'(OUT_VALID), 64'd0);
        set_op(3'd6, 3'd6, 1'b0, 32'h0, 3'b000, 3'd0, 1'b0);
        tick();
        check("flush_write_data1", 64'(OUT_DATA1), 64'h1234_5678);
        check("flush_write_data2", 64'(OUT_DATA2), 64'h1234_5678);

        // Flush with an empty stage and an incoming op: op is dropped.
        IN_VALID = 1'b0;
        tick();
        set_op(3'd3, 3'd4, 1'b0, 32'h0, 3'b110, 3'd3, 1'b1);
        FLUSH = 1'b1;
        tick();
        check("flush_empty_valid", 64'(OUT_VALID), 64'd0);
        FLUSH = 1'b0;
        IN_VALID = 1'b0;

        // Asynchronous reset mid-run while holding a live op.
        set_op(3'd3, 3'd4, 1'b0, 32'h0, 3'b100, 3'd6, 1'b1);
        OUT_READY = 1'b0;
        tick();
        check("pre_reset_valid", 64'(OUT_VALID), 64'd1);
        check("pre_reset_data1", 64'(OUT_DATA1), 64'h5);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_valid", 64'(OUT_VALID), 64'd0);
        check("async_reset_data1", 64'(OUT_DATA1), 64'd0);
        check("async_reset_data2", 64'(OUT_DATA2), 64'd0);
        check("async_reset_select", 64'(OUT_SELECT), 64'd0);
        check("async_reset_dest", 64'(OUT_DEST), 64'd0);
        check("async_reset_wb", 64'(OUT_WB), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        OUT_READY = 1'b1;

        // Every register reads back zero after reset.
        for (int i = 0; i < int'(NREGS); i++) begin
            set_op(AW'(i), AW'(NREGS - 1 - i), 1'b0, 32'h0, 3'b001, 3'd0, 1'b0);
            tick();
            check("reset_reg_valid", 64'(OUT_VALID), 64'd1);
            check("reset_reg_data1", 64'(OUT_DATA1), 64'd0);
            check("reset_reg_data2", 64'(OUT_DATA2), 64'd0);
        end
        IN_VALID = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
